// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the synchronous FIFO controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

  // Default payload width and entry count used by fifo_ctrl and fifo_mem.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Occupancy FSM: EMPTY means count == 0, FULL means count == DEPTH.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after wr_en; read is combinational.
// Backpressure: none; the controller decides when wr_en may fire.
//
// Ports:
//   clk      - write clock
//   wr_en    - write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr  - write index
//   wr_data  - write payload
//   rd_addr  - read index
//   rd_data  - contents of mem[rd_addr], combinational
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  // Storage carries no reset: the controller's pointers and state decide
  // which entries are meaningful.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/fifo_ctrl.sv
// Synchronous first-word-fall-through FIFO controller with status and sticky error flags.
// Latency: a push into an empty FIFO shows on rd_valid/rd_data the next cycle.
// Backpressure: wr_ready = !full and rd_valid = !empty, both from registered state only.
//
// Ports:
//   clk, rst                 - single clock; synchronous active-high reset
//   wr_valid/wr_data/wr_ready - write handshake, push = wr_valid && wr_ready
//   rd_valid/rd_data/rd_ready - read handshake, pop = rd_valid && rd_ready
//   flush                    - synchronous discard of all contents
//   count                    - current occupancy, 0..DEPTH
//   full/empty/almost_full/almost_empty - registered status decode
//   overflow/underflow       - sticky error flags, cleared by flush or rst
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   rd_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  fifo_state_e     state;
  fifo_state_e     state_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Handshakes qualify on registered ready/valid, so a pop while FULL cannot
  // free a slot for a push in the same cycle.
  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (flush wins over any handshake this cycle)
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) state_nxt = PARTIAL;
        end
        PARTIAL: begin
          if (push && !pop && (count == CNT_LAST)) begin
            state_nxt = FULL;
          end else if (pop && !push && (count == CNT_ONE)) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) state_nxt = PARTIAL;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state and count only
  // --------------------------------------------------------------------------
  always_comb begin
    full         = (state == FULL);
    empty        = (state == EMPTY);
    wr_ready     = (state != FULL);
    rd_valid     = (state != EMPTY);
    almost_full  = (count >= AFULL_C);
    almost_empty = (count <= AEMPTY_C);
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end

      // Errors are judged on the raw request, not the qualified handshake.
      if (wr_valid && full) overflow  <= 1'b1;
      if (rd_ready && empty) underflow <= 1'b1;
    end
  end

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl against a queue-based reference model.
// Latency: checks outputs each falling edge, one cycle after stimulus.
// Backpressure: model mirrors the ready/valid rules from occupancy only.
module tb_fifo_ctrl;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 8;
  localparam int AFULL_TH  = 6;
  localparam int AEMPTY_TH = 2;

  logic                   clk;
  logic                   rst;
  logic                   wr_valid;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_ready;
  logic                   rd_valid;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_ready;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;

  fifo_ctrl #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue plus the two sticky flags.
  logic [WIDTH-1:0] model_q[$];
  logic             model_ovf;
  logic             model_udf;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the FIFO.
  task automatic compare_all();
    int sz;
    sz = model_q.size();
    check_val("count",        32'(count),        32'(sz));
    check_val("full",         32'(full),         32'(sz == DEPTH));
    check_val("empty",        32'(empty),        32'(sz == 0));
    check_val("wr_ready",     32'(wr_ready),     32'(sz != DEPTH));
    check_val("rd_valid",     32'(rd_valid),     32'(sz != 0));
    check_val("almost_full",  32'(almost_full),  32'(sz >= AFULL_TH));
    check_val("almost_empty", 32'(almost_empty), 32'(sz <= AEMPTY_TH));
    check_val("overflow",     32'(overflow),     32'(model_ovf));
    check_val("underflow",    32'(underflow),    32'(model_udf));
    if (sz != 0) check_val("rd_data", 32'(rd_data), 32'(model_q[0]));
  endtask

  // One clock: check at the falling edge, drive, advance model on the rising edge.
  task automatic cyc(input logic wv, input logic [WIDTH-1:0] wd, input logic rr,
                     input logic fl, input logic rs);
    int  sz;
    logic do_push, do_pop;
    compare_all();
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    rst      = rs;
    @(posedge clk);
    sz = model_q.size();
    if (rs || fl) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      do_push = wv && (sz < DEPTH);
      do_pop  = rr && (sz > 0);
      if (wv && sz == DEPTH) model_ovf = 1'b1;
      if (rr && sz == 0)     model_udf = 1'b1;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    model_ovf = 1'b0;
    model_udf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values while rst is still held.
    check_val("rst_empty",    32'(empty),    32'd1);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill with 0x11..0x88, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      d = 8'(8'h11 * i);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
    end
    check_val("fill_full",  32'(full),     32'd1);
    check_val("fill_ready", 32'(wr_ready), 32'd0);
    check_val("fill_count", 32'(count),    32'd8);
    check_val("fill_head",  32'(rd_data),  32'h11);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_val("drain_empty", 32'(empty), 32'd1);

    // Wrap: push 5, pop 5, push 0xA0..0xA7, pop all.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    check_val("wrap_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Simultaneous push and pop at count 4 for 10 cycles.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, 1'b0);
    check_val("simul_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Overflow while full, then underflow while empty; both sticky until flush.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0);
    check_val("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    check_val("udf_set", 32'(underflow), 32'd1);
    check_val("ovf_hold", 32'(overflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Flush together with a push at count 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h6F, 1'b1, 1'b1, 1'b0);
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_empty", 32'(empty), 32'd1);

    // Reset together with a push at count 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h7F, 1'b1, 1'b0, 1'b1);
    check_val("rstmid_count",  32'(count),        32'd0);
    check_val("rstmid_aempty", 32'(almost_empty), 32'd1);

    // Threshold sweep 0 -> 8 -> 0, one step per cycle.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();

    // Randomized traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int wbias, rbias;
      wbias = ((i / 150) % 2 == 0) ? 80 : 30;
      rbias = 110 - wbias;
      cyc($urandom_range(0, 99) < wbias,
          8'($urandom()),
          $urandom_range(0, 99) < rbias,
          $urandom_range(0, 99) == 0,
          $urandom_range(0, 399) == 0);
    end
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_fifo_ctrl
